wall_spawn_scheduler: RTL and testbench
=======================================

WALL_SPAWN_SCHEDULER -- requirements
Module: wall_spawn_scheduler

Interface
REQ-001 SHALL have parameter SPAWN_INTERVAL, default 60, meaning frame_tick pulses between wall spawns (legal range 2..255).
REQ-002 SHALL have parameter MIN_HEIGHT, default 16, meaning the lowest wall height emitted.
REQ-003 SHALL have parameter MAX_HEIGHT, default 96, meaning the highest wall height emitted (MIN_HEIGHT <= MAX_HEIGHT <= 255).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of prefetched heights held (power of two, 2..8).
REQ-005 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn, input, 1, reset (asynchronous, active-low).
REQ-007 SHALL have port enable, input, 1, game running; gates prefetch and the spawn timer.
REQ-008 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-009 SHALL have port rnd_req, output, 1, request to the random height source.
REQ-010 SHALL have port rnd_valid, input, 1, one-cycle pulse marking rnd_data valid.
REQ-011 SHALL have port rnd_data, input, 8, raw random value.
REQ-012 SHALL have port wall_valid, output, 1, a wall height is offered to the game logic.
REQ-013 SHALL have port wall_ready, input, 1, game logic accepts the offered wall.
REQ-014 SHALL have port wall_height, output, 8, height of the offered wall.
REQ-015 SHALL have port fifo_count, output, 4, number of prefetched heights held.
REQ-016 SHALL have port spawn_overrun, output, 1, sticky flag set when a spawn interval expires while a spawn is still pending.

Function
REQ-017 SHALL implement a prefetch FSM with states IDLE, FETCH and WRITE; rnd_req = 1 exactly while in FETCH.
REQ-018 IDLE -> FETCH when enable = 1 and fifo_count < FIFO_DEPTH; otherwise remain in IDLE.
REQ-019 FETCH -> WRITE on the cycle rnd_valid = 1, capturing rnd_data; FETCH SHALL NOT be abandoned when enable drops, and SHALL wait for rnd_valid.
REQ-020 WRITE SHALL push the clamped value for one cycle, then go to FETCH if enable = 1 and the post-push count < FIFO_DEPTH, else IDLE.
REQ-021 Clamp: value < MIN_HEIGHT -> MIN_HEIGHT; value > MAX_HEIGHT -> MAX_HEIGHT; otherwise unchanged.
REQ-022 rnd_valid outside FETCH SHALL be ignored.
REQ-023 The FIFO SHALL be first-in-first-out; a simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 The frame counter SHALL increment on frame_tick while enable = 1 and hold while enable = 0.
REQ-025 On frame_tick with counter = SPAWN_INTERVAL-1, the counter SHALL clear to 0 and an internal spawn_due flag SHALL set.
REQ-026 If spawn_due is already set when REQ-025 fires, spawn_overrun SHALL set and remain set until reset; spawn_due SHALL stay set, and at most one spawn is pending.
REQ-027 When spawn_due = 1, fifo_count > 0 and wall_valid = 0, the FIFO head SHALL be popped into wall_height, wall_valid SHALL assert on the next cycle, and spawn_due SHALL clear.
REQ-028 If the FIFO is empty when spawn_due is set, the spawn SHALL be deferred until an entry is pushed; the pop SHALL occur the cycle after the push is visible.
REQ-029 wall_valid and wall_height SHALL hold stable until wall_ready = 1; wall_valid SHALL deassert the cycle after the wall_valid & wall_ready handshake.
REQ-030 A pending wall_valid SHALL complete its handshake regardless of enable.

Reset
REQ-031 On resetn = 0, the following SHALL be set asynchronously: FSM to IDLE, FIFO empty (fifo_count = 0), frame counter 0, spawn_due 0, rnd_req 0, wall_valid 0, wall_height 0, spawn_overrun 0.
REQ-032 Reset during FETCH or during a pending wall_valid SHALL drop rnd_req and wall_valid immediately; the interrupted request or offer is discarded.

Verification
REQ-033 Setup: reset, enable = 1, source answers each request after 3 cycles with values 5, 50, 200, 96. Required: fifo_count reaches 4; FIFO holds 16, 50, 96, 96; rnd_req = 0 once full.
REQ-034 Setup: SPAWN_INTERVAL = 4, full FIFO, wall_ready = 1. Required: wall_valid pulses after every 4th frame_tick, heights emitted in push order, and the FIFO refills.
REQ-035 Setup: wall_ready held 0 across two spawn intervals. Required: spawn_overrun = 1; after wall_ready is asserted, exactly one wall is accepted and then the next wall is offered.
REQ-036 Setup: source stalled so the FIFO is empty at spawn time, then rnd_valid arrives with rnd_data = 40. Required: wall_valid with wall_height = 40 within 3 cycles of rnd_valid.
REQ-037 Setup: enable drops in FETCH, then rnd_valid arrives. Required: the value is pushed, the FSM returns to IDLE, and the frame counter holds.
REQ-038 Setup: resetn pulsed low mid-FETCH with wall_valid = 1. Required: all outputs are 0 in the same cycle, and fifo_count = 0.

Source files
------------

// File: rtl/wall_spawn_scheduler.sv
// ============================================================================
// wall_spawn_scheduler
//
// Prefetches random wall heights into a small FIFO and releases one wall to
// the game logic every SPAWN_INTERVAL video frames.
//
// Parameters
//   SPAWN_INTERVAL  frame_tick pulses between wall spawns (2..255)
//   MIN_HEIGHT      lowest height emitted; raw values below are raised to it
//   MAX_HEIGHT      highest height emitted; raw values above are cut to it
//   FIFO_DEPTH      prefetched heights held (power of two, 2..8)
//
// Ports
//   clk            in   system clock, all state changes on its rising edge
//   resetn         in   asynchronous, active-low reset
//   enable         in   game running; gates prefetch and the spawn timer
//   frame_tick     in   one-cycle pulse per video frame
//   rnd_req        out  request to the random source (high exactly in FETCH)
//   rnd_valid      in   one-cycle pulse, rnd_data valid (ignored unless FETCH)
//   rnd_data[7:0]  in   raw random value
//   wall_valid     out  a wall height is offered
//   wall_ready     in   game logic accepts the offered wall
//   wall_height    out  height of the offered wall
//   fifo_count     out  number of prefetched heights held
//   spawn_overrun  out  sticky: an interval expired while a spawn was pending
//   fsm_state      out  prefetch FSM state (0 IDLE, 1 FETCH, 2 WRITE)
//
// Handshake (wall side): wall_valid/wall_height are set together and held
// unchanged until a rising edge sees wall_valid & wall_ready; wall_valid
// drops right after that edge. A new wall is only loaded while wall_valid
// is low, so an offer is never replaced or withdrawn except by reset.
// The random side is request/pulse: rnd_req stays high until one rnd_valid
// pulse is seen; pulses at any other time carry no meaning.
// ============================================================================
module wall_spawn_scheduler #(
    parameter int SPAWN_INTERVAL = 60,
    parameter int MIN_HEIGHT     = 16,
    parameter int MAX_HEIGHT     = 96,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       frame_tick,
    output logic       rnd_req,
    input  logic       rnd_valid,
    input  logic [7:0] rnd_data,
    output logic       wall_valid,
    input  logic       wall_ready,
    output logic [7:0] wall_height,
    output logic [3:0] fifo_count,
    output logic       spawn_overrun,
    output logic [1:0] fsm_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [3:0] DEPTH_C    = 4'(FIFO_DEPTH);
    localparam logic [7:0] MIN_C      = 8'(MIN_HEIGHT);
    localparam logic [7:0] MAX_C      = 8'(MAX_HEIGHT);
    localparam logic [7:0] LAST_FRAME = 8'(SPAWN_INTERVAL - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [7:0]       cap_val;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [3:0]       count;
    logic [3:0]       count_next;
    logic [7:0]       frame_cnt;
    logic             spawn_due;

    logic             push;
    logic             pop;
    logic             fire;

    function automatic logic [7:0] clamp_height(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v < MIN_C) begin
            r = MIN_C;
        end else if (v > MAX_C) begin
            r = MAX_C;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    // WRITE always pushes: FETCH is only entered with room in the FIFO and
    // nothing but the FSM fills it, so the slot is still free here.
    assign push = (state == ST_WRITE);

    // A pending spawn takes the FIFO head only when no offer is outstanding,
    // which keeps the offered wall stable until its handshake.
    assign pop  = spawn_due && (count != 4'd0) && !wall_valid;

    assign fire = enable && frame_tick && (frame_cnt == LAST_FRAME);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 4'd1;
            2'b01:   count_next = count - 4'd1;
            default: count_next = count;
        endcase
    end

    // ------------------------------------------------------------------
    // Prefetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (enable && (count < DEPTH_C)) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Once asked, the source is always waited for, even if the
                // game stops meanwhile; the answer is still kept.
                if (rnd_valid) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Decide on the occupancy after this push (and any
                // simultaneous pop) so the FIFO is never over-requested.
                if (enable && (count_next < DEPTH_C)) begin
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cap_val <= 8'd0;
        end else begin
            state <= state_next;
            if ((state == ST_FETCH) && rnd_valid) begin
                cap_val <= clamp_height(rnd_data);
            end
        end
    end

    assign rnd_req   = (state == ST_FETCH);
    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Height FIFO
    // ------------------------------------------------------------------
    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cap_val;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    assign fifo_count = count;

    // ------------------------------------------------------------------
    // Spawn timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt     <= 8'd0;
            spawn_due     <= 1'b0;
            spawn_overrun <= 1'b0;
        end else begin
            if (enable && frame_tick) begin
                if (fire) begin
                    frame_cnt <= 8'd0;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end

            // A new expiry wins over a same-cycle pop so the new spawn is
            // not lost; only one spawn is ever pending.
            if (fire) begin
                spawn_due <= 1'b1;
            end else if (pop) begin
                spawn_due <= 1'b0;
            end

            // Overrun only when the earlier spawn is really still waiting,
            // i.e. it is not being serviced on this very edge.
            if (fire && spawn_due && !pop) begin
                spawn_overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wall offer register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wall_valid  <= 1'b0;
            wall_height <= 8'd0;
        end else begin
            if (pop) begin
                wall_valid  <= 1'b1;
                wall_height <= mem[rd_ptr];
            end else if (wall_valid && wall_ready) begin
                wall_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wall_spawn_scheduler.sv
// ============================================================================
// tb_wall_spawn_scheduler
//
// Directed bench for wall_spawn_scheduler with SPAWN_INTERVAL = 4 and the
// default heights/depth. A background source answers each rnd_req about three
// cycles later from src_q and pushes the clamped value into exp_q; a monitor
// pops exp_q on every accepted wall and compares the height.
// ============================================================================
module tb_wall_spawn_scheduler;

  localparam int MINH = 16;
  localparam int MAXH = 96;

  // --------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------
  logic       clk;
  logic       resetn;
  logic       enable;
  logic       frame_tick;
  logic       rnd_req;
  logic       rnd_valid;
  logic [7:0] rnd_data;
  logic       wall_valid;
  logic       wall_ready;
  logic [7:0] wall_height;
  logic [3:0] fifo_count;
  logic       spawn_overrun;
  logic [1:0] dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wall_spawn_scheduler #(
    .SPAWN_INTERVAL(4),
    .MIN_HEIGHT    (MINH),
    .MAX_HEIGHT    (MAXH),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .frame_tick   (frame_tick),
    .rnd_req      (rnd_req),
    .rnd_valid    (rnd_valid),
    .rnd_data     (rnd_data),
    .wall_valid   (wall_valid),
    .wall_ready   (wall_ready),
    .wall_height  (wall_height),
    .fifo_count   (fifo_count),
    .spawn_overrun(spawn_overrun),
    .fsm_state    (dbg_state)
  );

  // --------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic       src_on;
  int         total;
  int         bad;

  function automatic logic [7:0] clampf(input logic [7:0] v);
    if (int'(v) < MINH) return 8'(MINH);
    if (int'(v) > MAXH) return 8'(MAXH);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------
  task automatic tick(input int gap);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_fifo(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while ((int'(fifo_count) != target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(fifo_count), 32'(target));
  endtask

  // Random source: answers a pending request about three cycles later.
  initial begin
    logic [7:0] v;
    rnd_valid = 1'b0;
    rnd_data  = 8'd0;
    forever begin
      @(negedge clk);
      if (resetn && src_on && rnd_req && (src_q.size() > 0)) begin
        repeat (2) @(negedge clk);
        if (resetn && rnd_req) begin
          v = src_q.pop_front();
          rnd_data  = v;
          rnd_valid = 1'b1;
          exp_q.push_back(clampf(v));
          @(negedge clk);
          rnd_valid = 1'b0;
        end
      end
    end
  end

  // Wall monitor: every accepted wall must match the next expected height.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (resetn && wall_valid && wall_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL wall_unexpected observed=%0d expected=none", wall_height);
        end else begin
          chk("wall_height", 32'(wall_height), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------
  initial begin
    int n;
    int lat;
    total      = 0;
    bad        = 0;
    resetn     = 1'b0;
    enable     = 1'b0;
    frame_tick = 1'b0;
    wall_ready = 1'b0;
    src_on     = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rnd_req",   32'(rnd_req),       0);
    chk("rst_wall_valid",32'(wall_valid),    0);
    chk("rst_wall_h",    32'(wall_height),   0);
    chk("rst_fifo",      32'(fifo_count),    0);
    chk("rst_overrun",   32'(spawn_overrun), 0);
    chk("rst_state",     32'(dbg_state),     0);

    // Prefetch fill with clamping: 5,50,200,96 -> 16,50,96,96
    src_q.push_back(8'd5);
    src_q.push_back(8'd50);
    src_q.push_back(8'd200);
    src_q.push_back(8'd96);
    resetn = 1'b1;
    enable = 1'b1;
    wait_fifo(4, 100, "fill_count");
    repeat (3) @(negedge clk);
    chk("full_no_req", 32'(rnd_req), 0);

    // Stray rnd_valid while idle must be ignored
    rnd_data  = 8'd77;
    rnd_valid = 1'b1;
    @(negedge clk);
    rnd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_ignored", 32'(fifo_count), 4);

    // Periodic spawns every 4th tick with refill
    src_q.push_back(8'd120);
    src_q.push_back(8'd30);
    src_q.push_back(8'd70);
    wall_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      repeat (3) tick(2);
      chk("pre_spawn_idle", 32'(wall_valid), 0);
      tick(0);
      @(negedge clk);
      chk("spawn_valid", 32'(wall_valid), 1);
      @(negedge clk);
      chk("spawn_drop", 32'(wall_valid), 0);
      repeat (8) @(negedge clk);
    end
    wait_fifo(4, 40, "refill_count");

    // Back-pressure across intervals -> overrun, one accept, next offer
    wall_ready = 1'b0;
    repeat (4) tick(2);
    chk("offer_held", 32'(wall_valid), 1);
    chk("offer_h", 32'(wall_height), 32'(exp_q[0]));
    repeat (8) tick(2);
    chk("overrun_set", 32'(spawn_overrun), 1);
    chk("offer_still", 32'(wall_valid), 1);
    chk("offer_h_stable", 32'(wall_height), 32'(exp_q[0]));
    wall_ready = 1'b1;
    @(negedge clk);
    wall_ready = 1'b0;
    chk("one_accepted", 32'(wall_valid), 0);
    @(negedge clk);
    chk("next_offer", 32'(wall_valid), 1);
    chk("next_offer_h", 32'(wall_height), 32'(exp_q[0]));
    wall_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("overrun_sticky", 32'(spawn_overrun), 1);

    // Empty FIFO at spawn time, then a late answer of 40
    src_on = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; (k < 6) && (fifo_count != 4'd0); k++) begin
      repeat (4) tick(2);
      repeat (4) @(negedge clk);
    end
    chk("drained", 32'(fifo_count), 0);
    repeat (4) tick(2);
    repeat (4) @(negedge clk);
    chk("deferred_wait", 32'(wall_valid), 0);
    src_q.push_back(8'd40);
    src_on = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!rnd_valid && (n < 20));
    chk("src_answer", 32'(rnd_valid), 1);
    lat = 0;
    while (!wall_valid && (lat < 3)) begin
      @(negedge clk);
      lat++;
    end
    chk("deferred_valid", 32'(wall_valid), 1);
    chk("deferred_h", 32'(wall_height), 40);

    // Enable drops during FETCH; answer still pushed; frame counter holds
    repeat (3) @(negedge clk);
    wall_ready = 1'b0;
    tick(2);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("fetch_kept", 32'(rnd_req), 1);
    src_q.push_back(8'd70);
    wait_fifo(1, 20, "push_after_disable");
    @(negedge clk);
    chk("idle_after_push", 32'(rnd_req), 0);
    repeat (4) tick(2);
    chk("counter_held", 32'(wall_valid), 0);
    enable = 1'b1;
    repeat (2) tick(2);
    chk("no_spawn_yet", 32'(wall_valid), 0);
    tick(0);
    @(negedge clk);
    chk("spawn_after_hold", 32'(wall_valid), 1);
    chk("spawn_after_hold_h", 32'(wall_height), 70);

    // Reset while fetching with an offer outstanding
    repeat (3) @(negedge clk);
    chk("pre_rst_req", 32'(rnd_req), 1);
    chk("pre_rst_valid", 32'(wall_valid), 1);
    resetn = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_req", 32'(rnd_req), 0);
    chk("mid_rst_valid", 32'(wall_valid), 0);
    chk("mid_rst_h", 32'(wall_height), 0);
    chk("mid_rst_fifo", 32'(fifo_count), 0);
    chk("mid_rst_overrun", 32'(spawn_overrun), 0);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
